// File: rtl/inst_encoder_loader.sv
// Instruction-memory loader: encodes compact commands into 32-bit MIPS words,
// buffers them in a small FIFO and writes them to consecutive word addresses.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   start, base_addr       session start pulse and first write address
//   cmd_*                  command stream (valid/ready handshake, cmd_last ends session)
//   imem_we/ready/addr/wdata  instruction-RAM write port with back-pressure
//   busy, done, bad_op, count  session status
module inst_encoder_loader #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_op,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_shamt,
  input  logic [15:0]       cmd_imm,
  input  logic [25:0]       cmd_target,
  input  logic              cmd_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              bad_op,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              fifo_full, fifo_empty;
  logic              push, pop, start_ok;
  logic [31:0]       enc_word;
  logic              enc_bad;

  assign fifo_full  = (occ == OCC_FULL);
  assign fifo_empty = (occ == '0);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = imem_we && imem_ready;
  assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
  // Head word is only meaningful while a write is requested; zero otherwise.
  assign imem_wdata = imem_we ? fifo_mem[rd_ptr] : 32'h0;

  // Command encoder
  always_comb begin
    logic       r_type, i_type, j_type, keep_shamt, lui;
    logic [5:0] funct, opc;
    enc_word   = 32'h0;
    enc_bad    = 1'b0;
    r_type     = 1'b0;
    i_type     = 1'b0;
    j_type     = 1'b0;
    keep_shamt = 1'b0;
    lui        = 1'b0;
    funct      = 6'h00;
    opc        = 6'h00;
    case (cmd_op)
      5'd0:  begin r_type = 1'b1; funct = 6'h20; end
      5'd1:  begin r_type = 1'b1; funct = 6'h22; end
      5'd2:  begin r_type = 1'b1; funct = 6'h24; end
      5'd3:  begin r_type = 1'b1; funct = 6'h25; end
      5'd4:  begin r_type = 1'b1; funct = 6'h2A; end
      5'd5:  begin r_type = 1'b1; funct = 6'h27; end
      5'd6:  begin r_type = 1'b1; funct = 6'h26; end
      5'd7:  begin r_type = 1'b1; funct = 6'h00; keep_shamt = 1'b1; end
      5'd8:  begin r_type = 1'b1; funct = 6'h02; keep_shamt = 1'b1; end
      5'd9:  begin r_type = 1'b1; funct = 6'h03; keep_shamt = 1'b1; end
      5'd10: begin r_type = 1'b1; funct = 6'h04; end
      5'd11: begin r_type = 1'b1; funct = 6'h06; end
      5'd12: begin r_type = 1'b1; funct = 6'h07; end
      5'd13: begin i_type = 1'b1; opc = 6'h23; end
      5'd14: begin i_type = 1'b1; opc = 6'h2B; end
      5'd15: begin i_type = 1'b1; opc = 6'h04; end
      5'd16: begin i_type = 1'b1; opc = 6'h08; end
      5'd17: begin j_type = 1'b1; end
      5'd18: begin i_type = 1'b1; opc = 6'h0C; end
      5'd19: begin i_type = 1'b1; opc = 6'h0F; lui = 1'b1; end
      5'd20: begin i_type = 1'b1; opc = 6'h0D; end
      5'd21: begin i_type = 1'b1; opc = 6'h0E; end
      default: enc_bad = 1'b1;
    endcase
    if (r_type)
      enc_word = {6'b0, cmd_rs, cmd_rt, cmd_rd, (keep_shamt ? cmd_shamt : 5'd0), funct};
    else if (i_type)
      enc_word = {opc, (lui ? 5'd0 : cmd_rs), cmd_rt, cmd_imm};
    else if (j_type)
      enc_word = {6'h02, cmd_target};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; DRAIN exits as soon as the last buffered word is popping.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_LOAD;
      S_LOAD:  if (push && cmd_last) state_nxt = S_DRAIN;
      S_DRAIN: if (fifo_empty || ((occ == OCC_W'(1)) && pop)) state_nxt = S_DONE;
      S_DONE:  if (start_ok) state_nxt = S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    cmd_ready = 1'b0;
    imem_we   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_LOAD:  begin busy = 1'b1; cmd_ready = !fifo_full; imem_we = !fifo_empty; end
      S_DRAIN: begin busy = 1'b1; imem_we = !fifo_empty; end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= enc_word;
  end

  // FIFO pointers, write address, count and sticky bad_op
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      imem_addr <= '0;
      count     <= '0;
      bad_op    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
      if (start_ok) begin
        imem_addr <= base_addr;
        count     <= '0;
        bad_op    <= 1'b0;
      end else begin
        if (pop) imem_addr <= imem_addr + ADDR_W'(1);
        if (pop && (count != CNT_MAX)) count <= count + CNT_W'(1);
        if (push && enc_bad) bad_op <= 1'b1;
      end
    end
  end

endmodule

// File: doc/inst_encoder_loader.md
# inst_encoder_loader

Assembles compact instruction commands into 32-bit MIPS instruction words and writes them sequentially into instruction memory. It is the program-loading counterpart of the main decoder: every encoding it emits is one the decoder consumes. It sits between a host-side command source (test harness or boot controller) and the instruction-RAM write port. A small FIFO decouples command acceptance from memory write back-pressure.

## Interface
Parameters:
- ADDR_W, 10, instruction-memory word-address width
- FIFO_DEPTH, 4, encoded-word buffer depth (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse that begins a load session; honoured only in IDLE or DONE
- base_addr  in  ADDR_W  first word address of the session, sampled with start
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  5  operation select (see Operation)
- cmd_rs, cmd_rt, cmd_rd, cmd_shamt  in  5 each  register and shift fields
- cmd_imm  in  16  immediate / branch offset
- cmd_target  in  26  jump target
- cmd_last  in  1  final command of the session
- imem_we  out  1  write request
- imem_ready  in  1  memory accepts the write this cycle
- imem_addr  out  ADDR_W  write word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  high in LOAD or DRAIN
- done  out  1  high in DONE
- bad_op  out  1  sticky: an undefined cmd_op was seen this session
- count  out  ADDR_W+1  words written this session

## Operation
- cmd_op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 NOR, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 SLLV, 11 SRLV, 12 SRAV, 13 LW, 14 SW, 15 BEQ, 16 ADDI, 17 J, 18 ANDI, 19 LUI, 20 ORI, 21 XORI; 22–31 undefined.
- R-type (0–12): {6'b0, rs, rt, rd, shamt, funct}. Funct values: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLT 0x2A, SLL 0x00, SRL 0x02, SRA 0x03, SLLV 0x04, SRLV 0x06, SRAV 0x07. The shamt field is forced to 0 for every R-type except SLL/SRL/SRA.
- I-type: {opcode, rs, rt, imm}. Opcodes: LW 0x23, SW 0x2B, BEQ 0x04, ADDI 0x08, ANDI 0x0C, ORI 0x0D, XORI 0x0E, LUI 0x0F. LUI forces rs to 0.
- J: {6'h02, target}.
- Undefined op: the word encodes as 32'h0 (NOP). It is still written, and bad_op sets.
- FSM states:
  - IDLE: on start, go to LOAD; imem_addr <= base_addr; count, bad_op cleared.
  - LOAD: cmd_ready = FIFO not full. Encode and push every accepted command. Accepting a command with cmd_last goes to DRAIN.
  - DRAIN: cmd_ready = 0. Go to DONE when the FIFO is empty and no write is pending.
  - DONE: done = 1. On start, go to LOAD with the same initialisation as from IDLE.
- Write side (LOAD/DRAIN): imem_we = FIFO not empty, and imem_wdata = FIFO head.
  - On imem_we && imem_ready: pop the head, imem_addr += 1, count += 1.
  - imem_addr wraps from 2^ADDR_W−1 to 0. count saturates at 2^ADDR_W.
- start outside IDLE/DONE is ignored.
- cmd_valid outside LOAD is ignored; nothing is pushed.

## Timing
- Reset values: state IDLE, FIFO empty, cmd_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, done 0, bad_op 0, count 0.
- Reset mid-session flushes the FIFO. Any pending write is abandoned, with imem_we low the next cycle.
- start in cycle N puts the block in LOAD with cmd_ready = 1 in cycle N+1.
- A command accepted in cycle N is presented at the earliest in cycle N+1 (registered FIFO, no bypass).
- With imem_ready held high, throughput is one word per cycle.
- cmd_ready depends only on FIFO occupancy. A simultaneous push and pop while full is not allowed (cmd_ready is already 0).
- imem_we, imem_addr and imem_wdata stay stable while imem_we && !imem_ready.
- The final write's handshake occurs in cycle M; done rises in cycle M+1, and busy falls in the same cycle.

## Test plan
- start with base_addr=0x010, then ADD rs=1 rt=2 rd=3 with cmd_last and shamt=7 → write 0x00221820 at addr 0x010; count=1; done rises one cycle after the handshake.
- LW rt=8 rs=29 imm=0x0004, SLL rd=4 rt=5 shamt=2, then J target=0x0000100 with cmd_last → 0x8FA80004, 0x00052080, 0x08000100 written at consecutive addresses.
- imem_ready held low while 6 commands are offered → exactly 4 accepted, then cmd_ready=0 and imem_we/addr/wdata held stable. On release, all 6 are written in order, one per cycle.
- base_addr=1023 (ADDR_W=10), two commands → writes at 1023 then 0; count=2.
- cmd_op=25 → wdata 0x00000000 and bad_op=1. bad_op stays 1 until the next start, then clears.
- resetn low for 1 cycle mid-DRAIN with 3 words buffered → next cycle IDLE, imem_we=0, count=0. No further writes until start.
